// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the 5-stage pipeline and its hazard/sequencing controller.
// The pipeline side is the master; pipe_ctrl attaches through the slave modport.
interface pipe_ctrl_if;
  logic        id_rs1_read_i;
  logic        id_rs2_read_i;
  logic [4:0]  id_rs1_addr_i;
  logic [4:0]  id_rs2_addr_i;
  logic        ex_load_i;
  logic        ex_wen_i;
  logic [4:0]  ex_rd_addr_i;
  logic        ex_jump_i;
  logic [31:0] ex_jump_addr_i;
  logic        ex_mc_req_i;
  logic        mc_done_i;
  logic [3:0]  stall_o;
  logic [2:0]  flush_o;
  logic        jump_o;
  logic [31:0] jump_addr_o;
  logic        mc_start_o;
  logic        mc_abort_o;

  modport master (
    output id_rs1_read_i, id_rs2_read_i, id_rs1_addr_i, id_rs2_addr_i,
           ex_load_i, ex_wen_i, ex_rd_addr_i, ex_jump_i, ex_jump_addr_i,
           ex_mc_req_i, mc_done_i,
    input  stall_o, flush_o, jump_o, jump_addr_o, mc_start_o, mc_abort_o
  );

  modport slave (
    input  id_rs1_read_i, id_rs2_read_i, id_rs1_addr_i, id_rs2_addr_i,
           ex_load_i, ex_wen_i, ex_rd_addr_i, ex_jump_i, ex_jump_addr_i,
           ex_mc_req_i, mc_done_i,
    output stall_o, flush_o, jump_o, jump_addr_o, mc_start_o, mc_abort_o
  );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline hazard controller: load-use stall, taken-jump squash and multicycle-op
// freeze/timeout, with a saturating count of PC-hold cycles.
module pipe_ctrl #(
  parameter int MC_TIMEOUT  = 40,
  parameter int STALL_CNT_W = 32
) (
  input  logic                   clk,
  input  logic                   rstn,
  pipe_ctrl_if.slave             bus,
  output logic [STALL_CNT_W-1:0] stall_cycles_o
);

  typedef enum logic {RUN, MC_WAIT} state_t;

  localparam logic [7:0] TIMEOUT_LAST = 8'(MC_TIMEOUT - 1);

  state_t                 state_reg, state_next;
  logic [7:0]             wait_cnt_reg, wait_cnt_next;
  logic [STALL_CNT_W-1:0] stall_cnt_reg;

  logic [3:0]  stall;
  logic [2:0]  flush;
  logic        jump;
  logic [31:0] jump_addr;
  logic        mc_start;
  logic        mc_abort;

  logic [1:0] src_read;
  logic [4:0] src_addr [2];
  logic [1:0] src_hit;
  logic       load_use;

  assign src_read    = {bus.id_rs2_read_i, bus.id_rs1_read_i};
  assign src_addr[0] = bus.id_rs1_addr_i;
  assign src_addr[1] = bus.id_rs2_addr_i;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_src
      assign src_hit[gi] = src_read[gi] && (src_addr[gi] == bus.ex_rd_addr_i);
    end
  endgenerate

  // x0 is never a real dependency, so a load targeting it cannot cause a stall.
  assign load_use = bus.ex_load_i && bus.ex_wen_i && (bus.ex_rd_addr_i != 5'd0) && (|src_hit);

  always_comb begin
    stall         = 4'b0000;
    flush         = 3'b000;
    jump          = 1'b0;
    jump_addr     = 32'd0;
    mc_start      = 1'b0;
    mc_abort      = 1'b0;
    state_next    = state_reg;
    wait_cnt_next = wait_cnt_reg;
    if (rstn) begin
      case (state_reg)
        RUN: begin
          if (bus.ex_jump_i) begin
            jump      = 1'b1;
            jump_addr = bus.ex_jump_addr_i;
            flush     = 3'b011;
          end else if (bus.ex_mc_req_i) begin
            mc_start      = 1'b1;
            stall         = 4'b0111;
            flush         = 3'b100;
            state_next    = MC_WAIT;
            wait_cnt_next = 8'd0;
          end else if (load_use) begin
            stall = 4'b0011;
            flush = 3'b010;
          end
        end
        MC_WAIT: begin
          // Done releases the freeze and lets the result into ex_mem; it beats timeout.
          if (bus.mc_done_i) begin
            state_next = RUN;
          end else if (wait_cnt_reg == TIMEOUT_LAST) begin
            mc_abort   = 1'b1;
            flush      = 3'b100;
            state_next = RUN;
          end else begin
            stall         = 4'b0111;
            flush         = 3'b100;
            wait_cnt_next = wait_cnt_reg + 8'd1;
          end
        end
        default: state_next = RUN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rstn) begin
      state_reg     <= RUN;
      wait_cnt_reg  <= 8'd0;
      stall_cnt_reg <= '0;
    end else begin
      state_reg    <= state_next;
      wait_cnt_reg <= wait_cnt_next;
      if (stall[0] && (stall_cnt_reg != '1)) begin
        stall_cnt_reg <= stall_cnt_reg + 1'b1;
      end
    end
  end

  assign bus.stall_o     = stall;
  assign bus.flush_o     = flush;
  assign bus.jump_o      = jump;
  assign bus.jump_addr_o = jump_addr;
  assign bus.mc_start_o  = mc_start;
  assign bus.mc_abort_o  = mc_abort;
  assign stall_cycles_o  = rstn ? stall_cnt_reg : '0;

endmodule
